door_sequencer: RTL and testbench
=================================

# door_sequencer

Parametrised door-cycle sequencer for the elevator controller: a full open/dwell/close state machine with per-phase timers, replacing fixed-period blink-only door handling. It sits between the floor/motion logic and the door actuator and indicators. It adds door-open/close buttons, obstruction reopen with a retry limit, and a `door_closed` interlock that the motion controller must see asserted before moving.

## Interface
- `CNT_W`, 26, timer/counter width in bits.
- `OPEN_TIME`, 26'd5000000, cycles spent in OPENING.
- `DWELL_TIME`, 26'd25000000, cycles door stays fully open.
- `CLOSE_TIME`, 26'd5000000, cycles spent in CLOSING.
- `BLINK_PERIOD`, 26'd2500000, cycles between `door_blink` toggles.
- `MAX_REOPEN`, 3, CLOSING→OPENING reversals allowed per door cycle before fault.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `floor_reached` in 1: car is level with a floor.
- `moving_up` in 1: car is moving up.
- `moving_down` in 1: car is moving down.
- `open_btn` in 1: door-open request, level.
- `close_btn` in 1: door-close request, level.
- `obstruct` in 1: obstruction sensor; 1 = blocked.
- `door_open` out 1: actuator drive; 1 in OPENING and OPEN.
- `door_closed` out 1: interlock; 1 only in CLOSED.
- `door_blink` out 1: indicator lamp.
- `reopen_fault` out 1: sticky reversal-limit flag.

## Operation
- States: CLOSED, OPENING, OPEN, CLOSING. `idle` = `floor_reached & ~moving_up & ~moving_down`.
- `served` flag: set on leaving OPEN or CLOSING into the next phase of a cycle. Cleared when `idle` is 0. It prevents automatic reopening at the same stop.
- CLOSED → OPENING when `idle & (~served | open_btn)`. Otherwise the FSM holds.
- OPENING → OPEN after exactly `OPEN_TIME` cycles. Buttons and `obstruct` are ignored.
- OPEN:
  - Dwell timer counts to `DWELL_TIME`, then → CLOSING.
  - `open_btn` or `obstruct` restarts the dwell timer at 0.
  - `close_btn` with `~obstruct` and `~open_btn` → CLOSING next cycle.
- CLOSING → CLOSED after exactly `CLOSE_TIME` cycles.
- CLOSING → OPENING (reversal) when `obstruct | open_btn`; reversal count increments by 1.
  - If the count would reach `MAX_REOPEN`, set `reopen_fault` and go to OPEN instead.
  - While `reopen_fault` = 1, OPEN does not time out while `obstruct` = 1.
- Reversal count and `reopen_fault` clear on entry to CLOSED.
- Timer resets to 0 on every state entry. It saturates and never wraps.
- `moving_up`/`moving_down` asserted outside CLOSED: no state change, since `door_closed` = 0 already blocks motion. `door_open` stays under FSM control.

## Timing
- Reset values:
  - state = CLOSED
  - `door_open` = 0, `door_closed` = 1, `door_blink` = 0, `reopen_fault` = 0
  - timers = 0, reversal count = 0, `served` = 0
- All outputs are registered; they reflect the new state the cycle after the transition edge.
- Request at edge N: state = OPENING at N+1, `door_open` = 1 and `door_closed` = 0 at N+1.
- A phase of length T occupies exactly T cycles.
- Simultaneous `open_btn` and `close_btn` in OPEN: open wins, dwell restarts.
- `rst` mid-cycle forces CLOSED on the next edge regardless of door position.
- `rst` has priority over every input.

## Configuration
- `DOOR_BLINK_EN` defined:
  - `door_blink` toggles every `BLINK_PERIOD` cycles while in OPENING or CLOSING.
  - Held 1 in OPEN; held 0 in CLOSED.
  - Blink counter resets on each state entry.
- `DOOR_BLINK_EN` undefined: `door_blink` = `door_open` and no blink counter is instantiated.

## Test plan
- Small params (OPEN=4, DWELL=10, CLOSE=4, MAX_REOPEN=2), `floor_reached`=1 and idle at cycle 5 → OPENING cycles 6–9, OPEN 10–19, CLOSING 20–23, CLOSED at 24; no second cycle while `floor_reached` stays 1.
- `open_btn` pulse at OPEN cycle 8 → dwell restarts; CLOSING entry is delayed to 10 cycles after the pulse.
- `close_btn` at OPEN cycle 2 → CLOSING next cycle; `door_closed`=1 exactly 4 cycles later.
- `obstruct` during CLOSING twice → first reverses to OPENING; second sets `reopen_fault`=1 and holds OPEN until `obstruct`=0. Fault clears on reaching CLOSED.
- `rst`=1 during OPEN → next edge: `door_open`=0, `door_closed`=1, `reopen_fault`=0.
- With `DOOR_BLINK_EN` and BLINK_PERIOD=2 → `door_blink` toggles every 2 cycles in OPENING; undefined → `door_blink` equals `door_open`.

Source files
------------

// File: rtl/door_sequencer.sv
// door_sequencer: open/dwell/close door FSM with per-phase timers, obstruction reversal limit
// and a door_closed motion interlock. Define DOOR_BLINK_EN for a flashing door_blink lamp.
module door_sequencer #(
    parameter int unsigned      CNT_W        = 26,
    parameter logic [CNT_W-1:0] OPEN_TIME    = 26'd5000000,
    parameter logic [CNT_W-1:0] DWELL_TIME   = 26'd25000000,
    parameter logic [CNT_W-1:0] CLOSE_TIME   = 26'd5000000,
    parameter logic [CNT_W-1:0] BLINK_PERIOD = 26'd2500000,
    parameter int unsigned      MAX_REOPEN   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic floor_reached,
    input  logic moving_up,
    input  logic moving_down,
    input  logic open_btn,
    input  logic close_btn,
    input  logic obstruct,
    output logic door_open,
    output logic door_closed,
    output logic door_blink,
    output logic reopen_fault
);

    localparam int unsigned RevW = (MAX_REOPEN < 1) ? 1 : $clog2(MAX_REOPEN + 1);
    localparam logic [RevW:0] RevMax = (RevW + 1)'(MAX_REOPEN);

    typedef enum logic [1:0] {
        StClosed,
        StOpening,
        StOpen,
        StClosing
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W:0]   timer_inc;
    logic [RevW-1:0]  rev_cnt_q, rev_cnt_d;
    logic             served_q, served_d;
    logic             fault_q, fault_d;
    logic             door_open_q, door_closed_q;
    logic             door_blink_q, door_blink_d;
    logic             idle, restart, served_set, rev_limit;

    assign idle      = floor_reached & ~moving_up & ~moving_down;
    assign timer_inc = {1'b0, timer_q} + (CNT_W + 1)'(1);
    assign rev_limit = ({1'b0, rev_cnt_q} + (RevW + 1)'(1)) >= RevMax;

    always_comb begin
        state_d    = state_q;
        rev_cnt_d  = rev_cnt_q;
        fault_d    = fault_q;
        restart    = 1'b0;
        served_set = 1'b0;
        unique case (state_q)
            StClosed: begin
                if (idle && (!served_q || open_btn)) begin
                    state_d = StOpening;
                end
            end
            StOpening: begin
                if (timer_inc >= {1'b0, OPEN_TIME}) begin
                    state_d = StOpen;
                end
            end
            StOpen: begin
                // Obstruction keeps restarting dwell, which also holds a faulted door open.
                if (open_btn || obstruct) begin
                    restart = 1'b1;
                end else if (close_btn || (timer_inc >= {1'b0, DWELL_TIME})) begin
                    state_d    = StClosing;
                    served_set = 1'b1;
                end
            end
            StClosing: begin
                if (obstruct || open_btn) begin
                    if (rev_limit) begin
                        fault_d   = 1'b1;
                        rev_cnt_d = RevMax[RevW-1:0];
                        state_d   = StOpen;
                    end else begin
                        rev_cnt_d = rev_cnt_q + RevW'(1);
                        state_d   = StOpening;
                    end
                end else if (timer_inc >= {1'b0, CLOSE_TIME}) begin
                    state_d    = StClosed;
                    served_set = 1'b1;
                    rev_cnt_d  = '0;
                    fault_d    = 1'b0;
                end
            end
            default: state_d = StClosed;
        endcase
    end

    always_comb begin
        if ((state_d != state_q) || restart) begin
            timer_d = '0;
        end else if (timer_inc[CNT_W]) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_inc[CNT_W-1:0];
        end
        // Leaving the stop re-arms the automatic opening for the next floor.
        served_d = idle & (served_q | served_set);
    end

`ifdef DOOR_BLINK_EN
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [CNT_W:0]   blink_inc;

    assign blink_inc = {1'b0, blink_cnt_q} + (CNT_W + 1)'(1);

    always_comb begin
        blink_cnt_d  = blink_cnt_q;
        door_blink_d = door_blink_q;
        if (state_d != state_q) begin
            blink_cnt_d  = '0;
            door_blink_d = (state_d != StClosed);
        end else if (state_q == StOpen) begin
            door_blink_d = 1'b1;
        end else if (state_q == StClosed) begin
            door_blink_d = 1'b0;
        end else if (blink_inc >= {1'b0, BLINK_PERIOD}) begin
            blink_cnt_d  = '0;
            door_blink_d = ~door_blink_q;
        end else begin
            blink_cnt_d = blink_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
        end
    end
`else
    assign door_blink_d = (state_d == StOpening) || (state_d == StOpen);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StClosed;
            timer_q       <= '0;
            rev_cnt_q     <= '0;
            served_q      <= 1'b0;
            fault_q       <= 1'b0;
            door_open_q   <= 1'b0;
            door_closed_q <= 1'b1;
            door_blink_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            rev_cnt_q     <= rev_cnt_d;
            served_q      <= served_d;
            fault_q       <= fault_d;
            door_open_q   <= (state_d == StOpening) || (state_d == StOpen);
            door_closed_q <= (state_d == StClosed);
            door_blink_q  <= door_blink_d;
        end
    end

    assign door_open    = door_open_q;
    assign door_closed  = door_closed_q;
    assign door_blink   = door_blink_q;
    assign reopen_fault = fault_q;

endmodule

// File: tb/tb_door_sequencer.sv
// Directed bench for door_sequencer with short phases (open 4, dwell 10, close 4, blink 2,
// two reversals before fault); blink checks follow DOOR_BLINK_EN.
module tb_door_sequencer;

    localparam int SC  = 0;
    localparam int SOG = 1;
    localparam int SO  = 2;
    localparam int SCG = 3;

    logic clk = 1'b0;
    logic rst, floor_reached, moving_up, moving_down, open_btn, close_btn, obstruct;
    logic door_open, door_closed, door_blink, reopen_fault;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    door_sequencer #(
        .CNT_W       (26),
        .OPEN_TIME   (26'd4),
        .DWELL_TIME  (26'd10),
        .CLOSE_TIME  (26'd4),
        .BLINK_PERIOD(26'd2),
        .MAX_REOPEN  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .floor_reached(floor_reached),
        .moving_up    (moving_up),
        .moving_down  (moving_down),
        .open_btn     (open_btn),
        .close_btn    (close_btn),
        .obstruct     (obstruct),
        .door_open    (door_open),
        .door_closed  (door_closed),
        .door_blink   (door_blink),
        .reopen_fault (reopen_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // s = expected phase, ph = cycle index within OPENING/CLOSING (-1 when not tracked)
    task automatic expect_st(input string tag, input int s, input int ph, input logic fault);
        logic e_open;
        e_open = (s == SOG) || (s == SO);
        chk({tag, ".door_open"}, door_open, e_open);
        chk({tag, ".door_closed"}, door_closed, s == SC);
        chk({tag, ".reopen_fault"}, reopen_fault, fault);
`ifdef DOOR_BLINK_EN
        if (s == SO) chk({tag, ".door_blink"}, door_blink, 1'b1);
        else if (s == SC) chk({tag, ".door_blink"}, door_blink, 1'b0);
        else if (ph >= 0) chk({tag, ".door_blink"}, door_blink, ((ph / 2) % 2) == 0);
`else
        chk({tag, ".door_blink"}, door_blink, e_open);
`endif
    endtask

    task automatic open_cycle_start(input string tag);
        open_btn = 1'b1;
        tick();
        expect_st({tag, ".opening0"}, SOG, 0, 1'b0);
        open_btn = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            expect_st($sformatf("%s.opening%0d", tag, i), SOG, i, 1'b0);
        end
        tick();
        expect_st({tag, ".open0"}, SO, -1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; floor_reached = 1'b0; moving_up = 1'b0; moving_down = 1'b0;
        open_btn = 1'b0; close_btn = 1'b0; obstruct = 1'b0;
        tick();
        tick();
        expect_st("reset", SC, -1, 1'b0);
        rst = 1'b0;
        repeat (3) tick();
        expect_st("no_floor", SC, -1, 1'b0);

        // Automatic cycle on arrival, then no second cycle at the same stop.
        floor_reached = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_st($sformatf("auto.opening%0d", i), SOG, i, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_st($sformatf("auto.open%0d", i), SO, -1, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_st($sformatf("auto.closing%0d", i), SCG, i, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_st($sformatf("served_hold%0d", i), SC, -1, 1'b0);
        end

        // open_btn at OPEN cycle 8 restarts dwell: CLOSING 10 cycles after the pulse.
        open_cycle_start("reopen");
        for (int i = 1; i < 9; i++) begin
            tick();
            expect_st($sformatf("reopen.open%0d", i), SO, -1, 1'b0);
        end
        open_btn = 1'b1;
        tick();
        expect_st("dwell_restart", SO, -1, 1'b0);
        open_btn = 1'b0;
        for (int i = 1; i < 10; i++) begin
            tick();
            expect_st($sformatf("restart.open%0d", i), SO, -1, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_st($sformatf("restart.closing%0d", i), SCG, i, 1'b0);
        end
        tick();
        expect_st("restart.closed", SC, -1, 1'b0);

        // Both buttons: open wins. Then close_btn at OPEN cycle 2.
        open_cycle_start("btns");
        tick();
        open_btn = 1'b1; close_btn = 1'b1;
        tick();
        expect_st("both_btn", SO, -1, 1'b0);
        open_btn = 1'b0; close_btn = 1'b0;
        tick();
        tick();
        expect_st("btns.open2", SO, -1, 1'b0);
        close_btn = 1'b1;
        tick();
        expect_st("close_btn.closing0", SCG, 0, 1'b0);
        close_btn = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            expect_st($sformatf("close_btn.closing%0d", i), SCG, i, 1'b0);
        end
        tick();
        expect_st("close_btn.closed", SC, -1, 1'b0);

        // Two obstructions while closing: reversal, then fault with door held open.
        open_cycle_start("obs");
        close_btn = 1'b1;
        tick();
        expect_st("obs.closing_a", SCG, 0, 1'b0);
        close_btn = 1'b0;
        obstruct = 1'b1;
        tick();
        expect_st("rev1", SOG, 0, 1'b0);
        obstruct = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            expect_st($sformatf("rev1.opening%0d", i), SOG, i, 1'b0);
        end
        tick();
        expect_st("rev1.open", SO, -1, 1'b0);
        close_btn = 1'b1;
        tick();
        expect_st("obs.closing_b", SCG, 0, 1'b0);
        close_btn = 1'b0;
        obstruct = 1'b1;
        tick();
        expect_st("rev2_fault", SO, -1, 1'b1);
        for (int i = 0; i < 15; i++) begin
            tick();
            expect_st($sformatf("fault_hold%0d", i), SO, -1, 1'b1);
        end
        obstruct = 1'b0;
        for (int i = 1; i < 10; i++) begin
            tick();
            expect_st($sformatf("fault.open%0d", i), SO, -1, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_st($sformatf("fault.closing%0d", i), SCG, i, 1'b1);
        end
        tick();
        expect_st("fault_cleared", SC, -1, 1'b0);

        // Reversal count cleared at CLOSED: one obstruction reverses again without fault.
        open_cycle_start("cnt");
        close_btn = 1'b1;
        tick();
        expect_st("cnt.closing", SCG, 0, 1'b0);
        close_btn = 1'b0;
        obstruct = 1'b1;
        tick();
        expect_st("count_cleared", SOG, 0, 1'b0);
        obstruct = 1'b0;
        repeat (3) tick();
        tick();
        expect_st("cnt.open", SO, -1, 1'b0);
        close_btn = 1'b1;
        tick();
        close_btn = 1'b0;
        obstruct = 1'b1;
        tick();
        expect_st("cnt.fault", SO, -1, 1'b1);

        // Reset in OPEN beats an active obstruction.
        rst = 1'b1;
        tick();
        expect_st("rst_in_open", SC, -1, 1'b0);
        rst = 1'b0; obstruct = 1'b0; floor_reached = 1'b0;
        tick();
        expect_st("after_rst", SC, -1, 1'b0);

        // Moving car is never idle, so the door stays shut.
        floor_reached = 1'b1; moving_up = 1'b1;
        tick();
        tick();
        expect_st("moving_up", SC, -1, 1'b0);
        moving_up = 1'b0; moving_down = 1'b1;
        tick();
        expect_st("moving_down", SC, -1, 1'b0);
        moving_down = 1'b0;
        tick();
        expect_st("arrive_open", SOG, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
